// File: rtl/ddr_req_sequencer_pkg.sv
// Shared types and constants for the DDR request sequencer: request word layout,
// FSM state encoding and default timing parameters.
package ddr_pkg;

    localparam int REQ_W     = 42;
    localparam int WDATA_LSB = 0;
    localparam int WDATA_W   = 16;
    localparam int ADDR_LSB  = 16;
    localparam int ADDR_W    = 23;
    localparam int BANK_LSB  = 39;
    localparam int BANK_W    = 2;
    localparam int WE_BIT    = 41;

    localparam int DEF_START_HOLD = 4;
    localparam int DEF_GAP_CYCLES = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RDY,
        S_GAP
    } seq_state_t;

    // Field order matches the packed FIFO word {we, bank, addr, wdata}.
    typedef struct packed {
        logic        we;
        logic [1:0]  bank;
        logic [22:0] addr;
        logic [15:0] wdata;
    } req_t;

    function automatic logic [REQ_W-1:0] pack_req(
        input logic              we,
        input logic [BANK_W-1:0] bank,
        input logic [ADDR_W-1:0] addr,
        input logic [WDATA_W-1:0] wdata
    );
        logic [REQ_W-1:0] v;
        v = '0;
        v[WE_BIT]                 = we;
        v[BANK_LSB +: BANK_W]     = bank;
        v[ADDR_LSB +: ADDR_W]     = addr;
        v[WDATA_LSB +: WDATA_W]   = wdata;
        return v;
    endfunction

endpackage

// File: rtl/ddr_req_sequencer_if.sv
// Request handshake between the image pipeline (master) and the DDR request sequencer (slave).
interface ddr_req_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_bank;
    logic [22:0] req_addr;
    logic [15:0] req_wdata;

    modport master (
        output req_valid, req_we, req_bank, req_addr, req_wdata,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_we, req_bank, req_addr, req_wdata,
        output req_ready
    );

endinterface

// File: rtl/ddr_req_fifo.sv
// Synchronous request FIFO with first-word fall-through read port and occupancy output.
module ddr_req_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 42
) (
    input  logic                   CLK_200MHz,
    input  logic                   WrStart,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];
    assign level    = count;

    // NOTE: storage carries no reset; validity is tracked by count, so only the pointers need clearing.
    always_ff @(posedge CLK_200MHz) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: every register in a clocked block uses <= so all flops update from pre-edge values.
    always_ff @(posedge CLK_200MHz or posedge WrStart) begin
        if (WrStart) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_req_sequencer.sv
// Buffers pipeline requests and issues them one at a time to the DDR controller.
// Optional watchdog on the ready wait: define DDR_REQ_TIMEOUT_EN.
module ddr_req_sequencer
    import ddr_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int START_HOLD = DEF_START_HOLD,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = 256
) (
    input  logic                   CLK_200MHz,
    input  logic                   WrStart,
    input  logic                   DevReady,
    ddr_req_sequencer_if.slave     req,
    output logic                   ctl_wr_start,
    input  logic                   ctl_wr_ready,
    output logic                   ctl_rd_start,
    input  logic                   ctl_rd_ready,
    output logic [1:0]             ctl_bank,
    output logic [22:0]            ctl_addr,
    output logic [15:0]            ctl_wdata,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int HOLD_W = $clog2(START_HOLD + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    seq_state_t       state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic             cur_we;
    logic [REQ_W-1:0] push_bits;
    logic [REQ_W-1:0] head_bits;
    req_t             head;
    logic             full;
    logic             empty;
    logic             pop;
    logic [2:0]       wr_sync;
    logic [2:0]       rd_sync;
    logic             wr_pulse;
    logic             rd_pulse;
    logic             match_pulse;
    logic             wd_expire;

    // Ready is held low during reset so nothing is accepted while the FIFO is being cleared.
    assign req.req_ready = !full && !WrStart;
    assign push_bits     = pack_req(req.req_we, req.req_bank, req.req_addr, req.req_wdata);
    assign head          = req_t'(head_bits);
    assign pop           = (state == S_IDLE) && DevReady && !empty;
    assign busy          = (state != S_IDLE) || !empty;

    ddr_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .CLK_200MHz (CLK_200MHz),
        .WrStart    (WrStart),
        .push       (req.req_valid && req.req_ready),
        .push_data  (push_bits),
        .pop        (pop),
        .pop_data   (head_bits),
        .full       (full),
        .empty      (empty),
        .level      (fifo_level)
    );

    // Bits [1:0] synchronise the controller-domain ready; bit 2 is the edge-detect history.
    always_ff @(posedge CLK_200MHz or posedge WrStart) begin
        if (WrStart) begin
            wr_sync <= '0;
            rd_sync <= '0;
        end else begin
            wr_sync <= {wr_sync[1:0], ctl_wr_ready};
            rd_sync <= {rd_sync[1:0], ctl_rd_ready};
        end
    end

    assign wr_pulse    = wr_sync[1] && !wr_sync[2];
    assign rd_pulse    = rd_sync[1] && !rd_sync[2];
    assign match_pulse = cur_we ? wr_pulse : rd_pulse;

`ifdef DDR_REQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT);
    logic [WD_W-1:0] wd_cnt;

    assign wd_expire = (state == S_WAIT_RDY) && !match_pulse && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge CLK_200MHz or posedge WrStart) begin
        if (WrStart) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            wd_cnt <= (state == S_WAIT_RDY) ? wd_cnt + 1'b1 : '0;
            if (wd_expire) err_timeout <= 1'b1;
        end
    end
`else
    assign wd_expire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge CLK_200MHz or posedge WrStart) begin
        if (WrStart) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            cur_we       <= 1'b0;
            ctl_wr_start <= 1'b0;
            ctl_rd_start <= 1'b0;
            ctl_bank     <= '0;
            ctl_addr     <= '0;
            ctl_wdata    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        ctl_bank  <= head.bank;
                        ctl_addr  <= head.addr;
                        ctl_wdata <= head.wdata;
                        cur_we    <= head.we;
                        hold_cnt  <= '0;
                        state     <= S_ISSUE;
                    end
                end
                // Fields were loaded one cycle earlier, so they are stable when start rises.
                S_ISSUE: begin
                    if (hold_cnt == HOLD_W'(START_HOLD)) begin
                        ctl_wr_start <= 1'b0;
                        ctl_rd_start <= 1'b0;
                        state        <= S_WAIT_RDY;
                    end else begin
                        ctl_wr_start <= cur_we;
                        ctl_rd_start <= !cur_we;
                        hold_cnt     <= hold_cnt + 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    if (match_pulse || wd_expire) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        ctl_bank  <= '0;
                        ctl_addr  <= '0;
                        ctl_wdata <= '0;
                        state     <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_req_sequencer.sv
// Self-checking bench for ddr_req_sequencer: scoreboard of accepted requests compared at each start rise.
`timescale 1ns/1ps
module tb_ddr_req_sequencer;
    import ddr_pkg::*;

    localparam int DEPTH      = 8;
    localparam int START_HOLD = 4;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 256;

    logic                   CLK_200MHz = 1'b0;
    logic                   WrStart;
    logic                   DevReady;
    logic                   ctl_wr_start;
    logic                   ctl_rd_start;
    logic                   ctl_wr_ready;
    logic                   ctl_rd_ready;
    logic [1:0]             ctl_bank;
    logic [22:0]            ctl_addr;
    logic [15:0]            ctl_wdata;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   busy;
    logic                   err_timeout;

    logic wr_rdy_auto  = 1'b0;
    logic rd_rdy_auto  = 1'b0;
    logic rd_rdy_stray = 1'b0;

    ddr_req_sequencer_if req_if ();

    assign ctl_wr_ready = wr_rdy_auto;
    assign ctl_rd_ready = rd_rdy_auto | rd_rdy_stray;

    ddr_req_sequencer #(
        .DEPTH      (DEPTH),
        .START_HOLD (START_HOLD),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .CLK_200MHz   (CLK_200MHz),
        .WrStart      (WrStart),
        .DevReady     (DevReady),
        .req          (req_if),
        .ctl_wr_start (ctl_wr_start),
        .ctl_wr_ready (ctl_wr_ready),
        .ctl_rd_start (ctl_rd_start),
        .ctl_rd_ready (ctl_rd_ready),
        .ctl_bank     (ctl_bank),
        .ctl_addr     (ctl_addr),
        .ctl_wdata    (ctl_wdata),
        .fifo_level   (fifo_level),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    always #2.5 CLK_200MHz = ~CLK_200MHz;

    int   n_checks = 0;
    int   n_errors = 0;
    req_t sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic req_t mk(input logic we, input logic [1:0] b, input logic [22:0] a, input logic [15:0] d);
        req_t r;
        r.we = we; r.bank = b; r.addr = a; r.wdata = d;
        return r;
    endfunction

    // Monitor and ready responder, evaluated on the falling edge.
    int   cyc = 0;
    int   n_starts = 0;
    int   n_falls = 0;
    int   last_start_cyc = 0;
    int   last_rdy_cyc = 0;
    int   hold_w = 0;
    int   rdy_timer = 0;
    int   rdy_hi = 0;
    int   rdy_delay = 3;
    bit   rdy_auto = 1'b0;
    logic prev_wr = 1'b0;
    logic prev_rd = 1'b0;
    logic rdy_pend = 1'b0;
    logic pend_we = 1'b0;
    req_t exp_r;

    always @(negedge CLK_200MHz) begin
        cyc++;
        if (WrStart) begin
            prev_wr = 1'b0; prev_rd = 1'b0; hold_w = 0;
            rdy_pend = 1'b0; rdy_hi = 0;
            wr_rdy_auto = 1'b0; rd_rdy_auto = 1'b0;
        end else begin
            if (ctl_wr_start && ctl_rd_start) check("both_starts", 1, 0);
            if ((ctl_wr_start && !prev_wr) || (ctl_rd_start && !prev_rd)) begin
                n_starts++;
                last_start_cyc = cyc;
                hold_w   = 0;
                rdy_pend = 1'b0;
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else begin
                    exp_r = sb.pop_front();
                    check("start_type_we", ctl_wr_start, exp_r.we);
                    check("ctl_bank", ctl_bank, exp_r.bank);
                    check("ctl_addr", ctl_addr, exp_r.addr);
                    check("ctl_wdata", ctl_wdata, exp_r.wdata);
                end
            end
            if (ctl_wr_start || ctl_rd_start) hold_w++;
            if ((!ctl_wr_start && prev_wr) || (!ctl_rd_start && prev_rd)) begin
                n_falls++;
                check("start_width", hold_w, START_HOLD);
                rdy_pend  = 1'b1;
                pend_we   = prev_wr;
                rdy_timer = rdy_delay;
            end
            if (rdy_hi > 0) begin
                rdy_hi--;
                if (rdy_hi == 0) begin wr_rdy_auto = 1'b0; rd_rdy_auto = 1'b0; end
            end else if (rdy_pend && rdy_auto) begin
                if (rdy_timer <= 1) begin
                    rdy_pend = 1'b0;
                    rdy_hi   = 4;
                    last_rdy_cyc = cyc;
                    if (pend_we) wr_rdy_auto = 1'b1; else rd_rdy_auto = 1'b1;
                end else rdy_timer--;
            end
            prev_wr = ctl_wr_start;
            prev_rd = ctl_rd_start;
        end
    end

    int acc_cyc;

    task automatic step(input int n);
        repeat (n) begin @(negedge CLK_200MHz); #1; end
    endtask

    task automatic push_req(input req_t r);
        int w;
        w = 0;
        req_if.req_valid = 1'b1;
        req_if.req_we    = r.we;
        req_if.req_bank  = r.bank;
        req_if.req_addr  = r.addr;
        req_if.req_wdata = r.wdata;
        while (!req_if.req_ready && w < 400) begin step(1); w++; end
        if (!req_if.req_ready) begin
            check("push_timeout", 0, 1);
            req_if.req_valid = 1'b0;
            return;
        end
        acc_cyc = cyc + 1;
        sb.push_back(r);
        step(1);
        req_if.req_valid = 1'b0;
    endtask

    task automatic wait_starts(input int target, input int budget);
        int w;
        w = 0;
        while (n_starts < target && w < budget) begin step(1); w++; end
        check("wait_starts", n_starts >= target, 1);
    endtask

    task automatic wait_falls(input int target, input int budget);
        int w;
        w = 0;
        while (n_falls < target && w < budget) begin step(1); w++; end
        check("wait_falls", n_falls >= target, 1);
    endtask

    task automatic wait_idle(input int budget);
        int w;
        w = 0;
        while (busy && w < budget) begin step(1); w++; end
        check("wait_idle", busy, 0);
    endtask

    int   base, f0, a_acc, a_start, rdy_c, bad, g;
    req_t ra;

    initial begin
        WrStart = 1'b1;
        DevReady = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_we = 1'b0;
        req_if.req_bank = '0;
        req_if.req_addr = '0;
        req_if.req_wdata = '0;
        step(3);
        check("rst_wr_start", ctl_wr_start, 0);
        check("rst_rd_start", ctl_rd_start, 0);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_if.req_ready, 0);
        check("rst_addr", ctl_addr, 0);
        check("rst_err", err_timeout, 0);
        WrStart = 1'b0;
        step(2);
        check("post_rst_ready", req_if.req_ready, 1);

        // Held off by DevReady, then drained in order.
        base = n_starts;
        for (int i = 0; i < 3; i++)
            push_req(mk(1'b1, 2'(i), 23'h100 + 23'(i), 16'h1000 + 16'(i)));
        step(10);
        check("t1_no_start", n_starts - base, 0);
        check("t1_level", fifo_level, 3);
        check("t1_busy", busy, 1);
        rdy_auto = 1'b1;
        DevReady = 1'b1;
        wait_starts(base + 3, 300);
        wait_idle(200);
        check("t1_sb_drained", sb.size(), 0);

        // Directed write: latency, field stability, ready-to-next-issue spacing.
        rdy_delay = 20;
        base = n_starts;
        ra = mk(1'b1, 2'b01, 23'h00_0405, 16'hBABE);
        push_req(ra);
        a_acc = acc_cyc;
        push_req(mk(1'b0, 2'b10, 23'h7F_0001, 16'h0000));
        wait_starts(base + 1, 50);
        check("t2_latency", last_start_cyc - a_acc, 2);
        a_start = last_start_cyc;
        bad = 0;
        g = 0;
        while (last_rdy_cyc <= a_start && g < 200) begin
            if ({ctl_bank, ctl_addr, ctl_wdata} != {ra.bank, ra.addr, ra.wdata}) bad++;
            step(1);
            g++;
        end
        check("t2_ready_seen", last_rdy_cyc > a_start, 1);
        rdy_c = last_rdy_cyc;
        // Sync (2) + edge detect (1) + GAP (4) keep the fields for 6 more sampled cycles.
        for (int i = 0; i < 6; i++) begin
            step(1);
            if ({ctl_bank, ctl_addr, ctl_wdata} != {ra.bank, ra.addr, ra.wdata}) bad++;
        end
        check("t2_fields_stable", bad, 0);
        wait_starts(base + 2, 100);
        // Ready seen -> sync 2 -> pulse -> GAP entry -> 4 GAP cycles -> pop -> start.
        check("t2_ready_to_issue", last_start_cyc - rdy_c, 9);
        wait_idle(200);

        // Fill to DEPTH with issue stalled; 9th accepted once the head pops.
        DevReady = 1'b0;
        rdy_auto = 1'b0;
        rdy_delay = 2;
        base = n_starts;
        for (int i = 0; i < 8; i++)
            push_req(mk(1'b1, 2'(i), 23'(i * 16 + 3), 16'hA000 + 16'(i)));
        check("t3_level_full", fifo_level, 8);
        check("t3_ready_full", req_if.req_ready, 0);
        fork
            push_req(mk(1'b0, 2'b11, 23'h55_5555, 16'h0009));
            begin
                step(5);
                check("t3_blocked", sb.size(), 8);
                DevReady = 1'b1;
            end
        join
        check("t3_level_after", fifo_level, 8);
        check("t3_started_one", n_starts - base, 1);
        f0 = n_falls;
        wait_falls(n_falls >= base + 1 ? f0 : f0 + 1, 50);
        rdy_auto = 1'b1;
        wait_starts(base + 9, 2000);
        wait_idle(300);
        check("t3_sb_drained", sb.size(), 0);

        // Alternating types; a stray read-ready during a write is ignored.
        rdy_delay = 30;
        base = n_starts;
        f0 = n_falls;
        push_req(mk(1'b1, 2'b00, 23'h00_1111, 16'h1111));
        push_req(mk(1'b0, 2'b01, 23'h00_2222, 16'h2222));
        push_req(mk(1'b1, 2'b10, 23'h00_3333, 16'h3333));
        push_req(mk(1'b0, 2'b11, 23'h00_4444, 16'h4444));
        wait_falls(f0 + 1, 100);
        step(1);
        rd_rdy_stray = 1'b1;
        step(5);
        rd_rdy_stray = 1'b0;
        step(12);
        check("t4_stray_ignored", n_starts - base, 1);
        wait_starts(base + 4, 1000);
        wait_idle(300);
        check("t4_sb_drained", sb.size(), 0);

        // Reset while waiting for ready drops everything.
        rdy_auto = 1'b0;
        base = n_starts;
        f0 = n_falls;
        push_req(mk(1'b1, 2'b01, 23'h12_3456, 16'hCAFE));
        wait_falls(f0 + 1, 50);
        push_req(mk(1'b0, 2'b00, 23'h00_0001, 16'h0001));
        push_req(mk(1'b1, 2'b00, 23'h00_0002, 16'h0002));
        step(3);
        WrStart = 1'b1;
        sb.delete();
        #1;
        check("t5_rst_wr_start", ctl_wr_start, 0);
        check("t5_rst_level", fifo_level, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_addr", ctl_addr, 0);
        check("t5_rst_req_ready", req_if.req_ready, 0);
        step(2);
        WrStart = 1'b0;
        step(2);
        check("t5_level_after", fifo_level, 0);
        check("t5_idle_after", busy, 0);
        check("t5_no_issue", n_starts - base, 1);
        rdy_auto = 1'b1;
        rdy_delay = 3;
        push_req(mk(1'b0, 2'b10, 23'h0A_BCDE, 16'h0000));
        wait_starts(base + 2, 50);
        wait_idle(200);

`ifdef DDR_REQ_TIMEOUT_EN
        // Watchdog: no ready for TIMEOUT cycles in WAIT_RDY sets the sticky flag.
        rdy_auto = 1'b0;
        base = n_starts;
        f0 = n_falls;
        push_req(mk(1'b1, 2'b11, 23'h33_0000, 16'hDEAD));
        wait_falls(f0 + 1, 50);
        step(TIMEOUT - 1);
        check("t6_err_before", err_timeout, 0);
        step(1);
        check("t6_err_set", err_timeout, 1);
        push_req(mk(1'b0, 2'b00, 23'h44_0000, 16'h0000));
        wait_starts(base + 2, 100);
        rdy_auto = 1'b1;
        wait_idle(200);
        check("t6_err_sticky", err_timeout, 1);
`else
        check("no_watchdog_err", err_timeout, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
